// File: rtl/ext_pipe.sv
// ext_pipe: registered immediate extender (sign/zero/top-aligned/shifted) for the decode->ALU path.
// Latency: 1 cycle from accept to out_valid. Throughput: 1 item/cycle with out_ready high.
// Backpressure: a one-entry skid absorbs the item arriving during a stall; in_ready drops while it is full.
// Optional build macro EXT_ERR_CNT_EN adds err_cnt, an 8-bit saturating count of accepted illegal-mode items.
module ext_pipe #(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int SHAMT  = 2,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  imm,
    input  logic [2:0]        eop,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
`ifdef EXT_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    // Extension modes; 101..111 are reserved and reported as errors.
    localparam logic [2:0] EOP_SEXT     = 3'b000;
    localparam logic [2:0] EOP_ZEXT     = 3'b001;
    localparam logic [2:0] EOP_TOP      = 3'b010;
    localparam logic [2:0] EOP_SEXT_SHL = 3'b011;
    localparam logic [2:0] EOP_ZEXT_SHL = 3'b100;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic              err;
    } item_t;

    logic              o_vld;
    item_t             o_item;
    logic              s_vld;
    item_t             s_item;
    item_t             new_item;

    logic [DATA_W-1:0] zext;
    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] top;

    logic              accept;
    logic              o_free;

    assign in_ready = ~s_vld & ~reset;
    assign accept   = in_valid & in_ready;
    assign o_free   = ~o_vld | out_ready;

    assign out_valid = o_vld;
    assign out_data  = o_item.data;
    assign out_tag   = o_item.tag;
    assign out_err   = o_item.err;

    // Build the extended operand for the incoming item. The sign fill is produced
    // by shifting an all-sign mask past the immediate; when IMM_W == DATA_W the
    // shift clears the whole mask, so sign- and zero-extension both pass imm as-is.
    always_comb begin
        zext = DATA_W'(imm);
        sext = zext | ({DATA_W{imm[IMM_W-1]}} << IMM_W);
        top  = zext << (DATA_W - IMM_W);

        new_item      = '0;
        new_item.tag  = in_tag;
        new_item.err  = 1'b0;
        case (eop)
            EOP_SEXT:     new_item.data = sext;
            EOP_ZEXT:     new_item.data = zext;
            EOP_TOP:      new_item.data = top;
            EOP_SEXT_SHL: new_item.data = sext << SHAMT;
            EOP_ZEXT_SHL: new_item.data = zext << SHAMT;
            default: begin
                new_item.data = '0;
                new_item.err  = 1'b1;
            end
        endcase
    end

    // Output register and skid: the skid drains into O first, so ordering stays FIFO
    // and the source is held (in_ready low) until the skid is empty again.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_vld  <= 1'b0;
            o_item <= '0;
            s_vld  <= 1'b0;
            s_item <= '0;
        end else if (o_free) begin
            if (s_vld) begin
                o_item <= s_item;
                o_vld  <= 1'b1;
                s_vld  <= 1'b0;
            end else if (accept) begin
                o_item <= new_item;
                o_vld  <= 1'b1;
            end else begin
                o_vld  <= 1'b0;
            end
        end else if (accept) begin
            s_item <= new_item;
            s_vld  <= 1'b1;
        end
    end

`ifdef EXT_ERR_CNT_EN
    // Count illegal-mode items once, at their accept event, saturating at 8'hFF.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt <= 8'h00;
        end else if (accept && new_item.err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: directed checks of ext_pipe modes, skid back-pressure, streaming and reset.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: exercised by holding out_ready low with in_valid asserted.
module tb_ext_pipe;

    logic        clk;
    logic        reset;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] imm;
    logic [2:0]  eop;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        out_err;

    logic        w_in_valid;
    logic        w_in_ready;
    logic [31:0] w_imm;
    logic [2:0]  w_eop;
    logic [4:0]  w_in_tag;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [31:0] w_out_data;
    logic [4:0]  w_out_tag;
    logic        w_out_err;

`ifdef EXT_ERR_CNT_EN
    logic [7:0]  err_cnt;
    logic [7:0]  w_err_cnt;
`endif

    int checks;
    int failures;

    ext_pipe #(.IMM_W(16), .DATA_W(32), .SHAMT(2), .TAG_W(5)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm       (imm),
        .eop       (eop),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_err   (out_err)
`ifdef EXT_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    ext_pipe #(.IMM_W(32), .DATA_W(32), .SHAMT(0), .TAG_W(5)) u_wide (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .imm       (w_imm),
        .eop       (w_eop),
        .in_tag    (w_in_tag),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .out_data  (w_out_data),
        .out_tag   (w_out_tag),
        .out_err   (w_out_err)
`ifdef EXT_ERR_CNT_EN
        ,
        .err_cnt   (w_err_cnt)
`endif
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Independent reference for the default configuration (IMM_W=16, DATA_W=32, SHAMT=2).
    function automatic logic [31:0] ref_data(input logic [15:0] i, input logic [2:0] m);
        logic [31:0] s;
        logic [31:0] z;
        s = {{16{i[15]}}, i};
        z = {16'h0000, i};
        case (m)
            3'b000:  return s;
            3'b001:  return z;
            3'b010:  return {i, 16'h0000};
            3'b011:  return {s[29:0], 2'b00};
            3'b100:  return {z[29:0], 2'b00};
            default: return 32'h0;
        endcase
    endfunction

    logic [31:0] sweep_exp [5];
    logic [31:0] exp_d;
    logic [31:0] held_d;
    int          exp_errs;

    initial begin
        checks      = 0;
        failures    = 0;
        exp_errs    = 0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        imm         = '0;
        eop         = '0;
        in_tag      = '0;
        out_ready   = 1'b0;
        w_in_valid  = 1'b0;
        w_imm       = '0;
        w_eop       = '0;
        w_in_tag    = '0;
        w_out_ready = 1'b1;

        sweep_exp[0] = 32'hFFFF8001;
        sweep_exp[1] = 32'h00008001;
        sweep_exp[2] = 32'h80010000;
        sweep_exp[3] = 32'hFFFE0004;
        sweep_exp[4] = 32'h00020004;

        // Reset state.
        step();
        step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_tag",   64'(out_tag),   64'd0);
        chk("rst_out_err",   64'(out_err),   64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
`ifdef EXT_ERR_CNT_EN
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
`endif

        // Legal mode sweep, back-to-back with out_ready high.
        out_ready = 1'b1;
        for (int m = 0; m < 5; m++) begin
            in_valid = 1'b1;
            imm      = 16'h8001;
            eop      = 3'(m);
            in_tag   = 5'(m + 4);
            step();
            chk($sformatf("sweep%0d_valid", m), 64'(out_valid), 64'd1);
            chk($sformatf("sweep%0d_data", m),  64'(out_data),  64'(sweep_exp[m]));
            chk($sformatf("sweep%0d_err", m),   64'(out_err),   64'd0);
            chk($sformatf("sweep%0d_tag", m),   64'(out_tag),   64'(m + 4));
        end

        // Illegal modes.
        for (int m = 5; m < 8; m++) begin
            imm    = 16'h1234;
            eop    = 3'(m);
            in_tag = 5'(m);
            step();
            chk($sformatf("illegal%0d_valid", m), 64'(out_valid), 64'd1);
            chk($sformatf("illegal%0d_data", m),  64'(out_data),  64'd0);
            chk($sformatf("illegal%0d_err", m),   64'(out_err),   64'd1);
        end
        exp_errs = 3;
        in_valid = 1'b0;
        step();
        chk("drain_valid", 64'(out_valid), 64'd0);
`ifdef EXT_ERR_CNT_EN
        chk("err_cnt_3", 64'(err_cnt), 64'd3);
`endif

        // Back-pressure: tag1 into O, tag2 into skid, tag3 held by the source.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        eop       = 3'b001;
        imm       = 16'h0011;
        in_tag    = 5'd1;
        step();
        chk("bp_t1_valid", 64'(out_valid), 64'd1);
        chk("bp_t1_tag",   64'(out_tag),   64'd1);
        chk("bp_t1_ready", 64'(in_ready),  64'd1);
        imm    = 16'h0012;
        in_tag = 5'd2;
        step();
        chk("bp_t2_ready", 64'(in_ready), 64'd0);
        chk("bp_t2_tag",   64'(out_tag),  64'd1);
        imm    = 16'h0013;
        in_tag = 5'd3;
        step();
        chk("bp_hold_ready", 64'(in_ready), 64'd0);
        chk("bp_hold_tag",   64'(out_tag),  64'd1);
        chk("bp_hold_data",  64'(out_data), 64'h11);
        out_ready = 1'b1;
        step();
        chk("bp_out2_valid", 64'(out_valid), 64'd1);
        chk("bp_out2_tag",   64'(out_tag),   64'd2);
        chk("bp_out2_data",  64'(out_data),  64'h12);
        chk("bp_out2_ready", 64'(in_ready),  64'd1);
        step();
        chk("bp_out3_valid", 64'(out_valid), 64'd1);
        chk("bp_out3_tag",   64'(out_tag),   64'd3);
        chk("bp_out3_data",  64'(out_data),  64'h13);
        in_valid = 1'b0;
        step();
        chk("bp_drain_valid", 64'(out_valid), 64'd0);

        // Streaming: 100 random items, one result per cycle.
        for (int k = 0; k < 100; k++) begin
            in_valid = 1'b1;
            imm      = 16'($urandom);
            eop      = 3'($urandom_range(0, 7));
            in_tag   = 5'(k);
            exp_d    = ref_data(imm, eop);
            if (eop > 3'b100) exp_errs++;
            #1;
            chk($sformatf("st%0d_in_ready", k), 64'(in_ready), 64'd1);
            step();
            chk($sformatf("st%0d_valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("st%0d_data", k),  64'(out_data),  64'(exp_d));
            chk($sformatf("st%0d_tag", k),   64'(out_tag),   64'(k % 32));
            chk($sformatf("st%0d_err", k),   64'(out_err),   64'(eop > 3'b100));
        end
        in_valid = 1'b0;
        step();
`ifdef EXT_ERR_CNT_EN
        chk("st_err_cnt", 64'(err_cnt), 64'(exp_errs));
`endif

        // Reset while both O and skid are full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        eop       = 3'b001;
        imm       = 16'h00A1;
        in_tag    = 5'd10;
        step();
        imm    = 16'h00A2;
        in_tag = 5'd11;
        step();
        chk("rs_full_ready", 64'(in_ready), 64'd0);
        chk("rs_full_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("rs_during_ready", 64'(in_ready), 64'd0);
        step();
        chk("rs_valid", 64'(out_valid), 64'd0);
        chk("rs_data",  64'(out_data),  64'd0);
        chk("rs_ready", 64'(in_ready),  64'd0);
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rs_after_ready", 64'(in_ready), 64'd1);
`ifdef EXT_ERR_CNT_EN
        chk("rs_err_cnt", 64'(err_cnt), 64'd0);
`endif
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("rs_no_replay%0d", k), 64'(out_valid), 64'd0);
        end

        // Wide instance: IMM_W == DATA_W, SHAMT = 0.
        w_imm = 32'h8000_0000;
        for (int m = 0; m < 5; m++) begin
            w_in_valid = 1'b1;
            w_eop      = 3'(m);
            w_in_tag   = 5'(m);
            step();
            chk($sformatf("wide%0d_valid", m), 64'(w_out_valid), 64'd1);
            chk($sformatf("wide%0d_data", m),  64'(w_out_data),  64'h8000_0000);
            chk($sformatf("wide%0d_err", m),   64'(w_out_err),   64'd0);
        end
        w_in_valid = 1'b0;
        held_d     = 32'h0000_0001;
        w_imm      = held_d;
        w_eop      = 3'b000;
        w_in_valid = 1'b1;
        step();
        chk("wide_pos_data", 64'(w_out_data), 64'(held_d));
        w_in_valid = 1'b0;
        step();
        chk("wide_drain_valid", 64'(w_out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
- Parametrised, registered immediate extender for the pipelined datapath.
- Takes an IMM_W-bit immediate with a 3-bit mode and a tag. Produces a DATA_W-bit extended/shifted operand.
- Uses a valid/ready handshake on both sides, with a one-entry skid buffer so full throughput is kept under back-pressure.
- Sits between decode and the operand-select/ALU stage.

Parameters:
- IMM_W, 16, immediate width; legal range 1..DATA_W.
- DATA_W, 32, output operand width.
- SHAMT, 2, left-shift amount for the shifted modes; legal range 0..DATA_W-1.
- TAG_W, 5, width of the sideband tag carried alongside each item.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request this cycle.
- imm  input  IMM_W  immediate field.
- eop  input  3  extension mode.
- in_tag  input  TAG_W  sideband, e.g. destination register number.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result this cycle.
- out_data  output  DATA_W  extended result.
- out_tag  output  TAG_W  tag of the result.
- out_err  output  1  eop was illegal for this item.

Behaviour:
- Clocking: single clock clk. reset is synchronous, active-high, sampled on the rising edge.
- Reset values: out_valid=0, out_data=0, out_tag=0, out_err=0, skid empty. in_ready=0 while reset is high and 1 in the first cycle after reset is released.
- Modes (computed combinationally from the incoming item, then registered):
  - 000: sign-extend imm to DATA_W.
  - 001: zero-extend imm.
  - 010: imm in the top bits, {imm, (DATA_W-IMM_W) zeros}.
  - 011: sign-extend, then shift left by SHAMT; bits above DATA_W discarded.
  - 100: zero-extend, then shift left by SHAMT; bits above DATA_W discarded.
  - 101/110/111: illegal; result 0, err=1.
  - err=0 for all legal modes.
- Storage: output register O (out_* ports) and skid register S (valid, data, tag, err).
  - in_ready = ~S.valid & ~reset.
  - Accept event: in_valid & in_ready.
- Per-cycle update, evaluated at each rising edge when reset is low:
  - O free (~O.valid | out_ready) and S.valid: O <= S; S.valid <= 0. A simultaneous accept is impossible because in_ready=0.
  - O free and S empty: O <= accepted item if accept, else O.valid <= 0.
  - O stalled (O.valid & ~out_ready) and accept: S <= accepted item.
  - O stalled, no accept: O and S hold.
- Latency and throughput:
  - Accept at edge N gives out_valid at edge N when empty, i.e. visible in the cycle after acceptance: latency 1 cycle.
  - With out_ready held high: 1 item/cycle sustained.
- Ordering: strictly FIFO. No item is lost or duplicated.
- While out_valid=1 and out_ready=0, out_data/out_tag/out_err are stable.
- Reset mid-operation: both O and S are discarded. out_valid=0 on the next cycle. Items in flight are dropped, not replayed.
- Width rules:
  - IMM_W==DATA_W: modes 000, 001 and 010 all pass imm unchanged.
  - SHAMT=0: mode 011 equals 000 and mode 100 equals 001.

Optional Feature:
- Macro: EXT_ERR_CNT_EN.
- Defined:
  - Adds output port err_cnt (8 bits).
  - Counts illegal-mode items at their accept event. Saturates at 8'hFF. Cleared to 0 by reset.
  - Counts only items that are accepted; a held, un-accepted request is not counted.
- Undefined:
  - No err_cnt port and no counter logic.
  - out_err behaviour is identical in both builds.

Test Plan:
- Mode sweep (defaults), out_ready=1, imm=16'h8001, eop 000..100 -> out_data 32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFE0004, 32'h00020004; out_err=0; each valid one cycle after accept.
- Illegal modes: eop=3'b101, 110, 111 with imm=16'h1234 -> out_data=0, out_err=1. With EXT_ERR_CNT_EN, err_cnt=3.
- Back-pressure: out_ready=0, push tags 1, 2, 3 back-to-back.
  - Tag1 lands in O, tag2 in S; in_ready=0 from the cycle after tag2 is accepted; tag3 is held by the source.
  - Raise out_ready: outputs tag1, tag2, tag3 in order, no gaps after tag2.
- Streaming: 100 random items with out_ready=1 and in_valid=1 -> one result per cycle, in_ready never drops, data matches the reference model.
- Reset mid-stall: O and S full, assert reset for 1 cycle -> out_valid=0, out_data=0, in_ready=0 during reset and 1 after. Old items never appear.
- Parameter corner: IMM_W=32, DATA_W=32, SHAMT=0, imm=32'h8000_0000 -> modes 000/010/011 give 32'h80000000; mode 100 gives the same.
